pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, data bits carried per transfer.
REQ-002 Parameter RESET_DATA, default all-zero, WIDTH-bit value loaded into both data registers at reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  stage can accept a word this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 flush  input  1  squash all held words; highest priority after rst.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  oldest held word.
REQ-012 count  output  2  occupancy, 0..2.

Function
REQ-013 in_fire = in_valid & in_ready & !flush; out_fire = out_valid & out_ready; flush suppresses in_fire.
REQ-014 Storage: main register (drives out_data) plus skid register; states EMPTY, ONE, FULL.
REQ-015 EMPTY: in_fire -> ONE, main <= in_data; otherwise stay.
REQ-016 ONE: in_fire & out_fire -> ONE, main <= in_data.
REQ-017 ONE: in_fire & !out_fire -> FULL, skid <= in_data.
REQ-018 ONE: !in_fire & out_fire -> EMPTY; neither -> hold.
REQ-019 FULL: out_fire -> ONE, main <= skid; otherwise hold; no in_fire possible.
REQ-020 in_ready = (state != FULL), decoded from registered state only; no combinational path from out_ready to in_ready.
REQ-021 out_valid = (state != EMPTY); count = 0/1/2 for EMPTY/ONE/FULL.
REQ-022 Latency: word accepted at edge k appears on out_data with out_valid=1 after edge k; sustained throughput one word per cycle when out_ready held high.
REQ-023 Order preserved; no word duplicated or dropped except by flush or rst.
REQ-024 Held data stable while out_valid=1 and out_ready=0.
REQ-025 flush=1 at an edge: next state EMPTY regardless of in_valid/out_ready; data registers keep contents (don't-care); an out_fire coinciding with flush still counts as delivered downstream.
REQ-026 Flush in EMPTY is a no-op; back-to-back flush keeps EMPTY.

Reset
REQ-027 rst=0 at an edge: state EMPTY, main and skid <= RESET_DATA, in_ready=1, out_valid=0, count=0 after the edge.
REQ-028 rst overrides flush and any in-flight handshake, including mid-FULL; held words are discarded.
REQ-029 No asynchronous reset path; state between power-up and first reset edge is unspecified.

Structure
REQ-030 Shared package pipe_pkg holds the state enumeration (EMPTY, ONE, FULL) and the default WIDTH constant.
REQ-031 One sub-module, pipe_en_reg: WIDTH-bit register with load enable and synchronous active-low reset to RESET_DATA, instantiated for main and skid.
REQ-032 Control FSM and handshake decode live in pipe_stage_reg; no latches, single always-block per register group.

Verification
REQ-033 Reset: rst=0 for 2 cycles with in_valid=1, in_data=0xAAAA5555 -> out_valid=0, count=0, in_ready=1, out_data=RESET_DATA.
REQ-034 Streaming: out_ready=1, in_valid=1 with 0x1,0x2,0x3,0x4 on consecutive cycles -> out_data 0x1..0x4 on the following four cycles, count stays 1.
REQ-035 Backpressure: out_ready=0, send 0x10,0x20 -> count=2, in_ready=0, 0x30 held off; raise out_ready -> 0x10,0x20,0x30 emerge in order, none lost.
REQ-036 Flush in FULL: hold 0x10,0x20, assert flush with in_valid=1 in_data=0x99 -> next cycle count=0, out_valid=0; 0x99 never appears.
REQ-037 Reset mid-operation: FULL with 0x10,0x20, rst=0 together with flush=1 -> EMPTY, out_data=RESET_DATA; after release 0x5 streams through with 1-cycle latency.
REQ-038 Random bench: random in_valid/out_ready/flush for 10k cycles, scoreboard checks order, no loss outside flush, and in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the two-entry pipeline stage: occupancy states and default width.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_en_reg.sv
// Data register with load enable and synchronous active-low reset to a fixed value.
module pipe_en_reg #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RESET_DATA;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage; in_ready is decoded from registered state only.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    state_t           state_q, state_d;
    logic             in_fire, out_fire;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d, skid_q;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign count     = (state_q == FULL) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;

    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = out_valid & out_ready;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_en = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush empties the stage and leaves both data registers untouched.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_en_reg #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    pipe_en_reg #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

endmodule
